// File: rtl/lpc_pkg.sv
// rtl/lpc_pkg.sv - shared constants, FSM encoding and helpers for the pitch/voicing analyser
package lpc_pkg;

    localparam int FRAME_LEN_DEFAULT  = 240;
    localparam int ZC_HYST_DEFAULT    = 256;
    localparam int ENERGY_THR_DEFAULT = 120000;
    localparam int ZC_MAX_DEFAULT     = 60;
    localparam int MIN_PERIOD_DEFAULT = 20;
    localparam int MAX_PERIOD_DEFAULT = 160;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Magnitude of a 16-bit two's complement sample; 17 bits so -32768 maps to 32768
    function automatic logic [16:0] abs17(input logic [15:0] s);
        logic signed [16:0] w;
        w = $signed({s[15], s});
        return s[15] ? 17'(-w) : 17'(w);
    endfunction

endpackage

// File: rtl/lpc_zero_cross_tracker.sv
// rtl/lpc_zero_cross_tracker.sv - hysteretic positive-crossing detector and period tracker
module lpc_zero_cross_tracker
    import lpc_pkg::*;
#(
    parameter int ZC_HYST    = ZC_HYST_DEFAULT,
    parameter int MAX_PERIOD = MAX_PERIOD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        v,
    input  logic [15:0] x,
    output logic        crossing,
    output logic        seen_next,
    output logic [15:0] last_period_next
);

    localparam logic [15:0] PER_SAT = 16'(MAX_PERIOD + 1);

    logic               armed;
    logic               seen;
    logic [15:0]        per_cnt;
    logic [15:0]        last_period;
    logic signed [16:0] xs;
    logic signed [16:0] hyst;
    logic               arm_cond;

    assign xs       = $signed({x[15], x});
    assign hyst     = 17'(ZC_HYST);
    assign arm_cond = (xs < -hyst);

    // Crossing and post-sample views are combinational so the parent can decide a frame on its last sample
    always_comb begin
        crossing         = v && armed && (xs >= hyst);
        seen_next        = crossing ? 1'b1 : seen;
        last_period_next = (crossing && seen) ? per_cnt : last_period;
    end

    // Tracker state persists across frames; only reset clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            armed       <= 1'b0;
            seen        <= 1'b0;
            per_cnt     <= '0;
            last_period <= '0;
        end else if (v) begin
            if (crossing)
                armed <= 1'b0;
            else if (arm_cond)
                armed <= 1'b1;
            seen        <= seen_next;
            last_period <= last_period_next;
            if (crossing)
                per_cnt <= 16'd1;
            else if (per_cnt >= PER_SAT)
                per_cnt <= PER_SAT;
            else
                per_cnt <= per_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/lpc_pitch_voicing.sv
// rtl/lpc_pitch_voicing.sv - per-frame pitch period and voiced decision
module lpc_pitch_voicing
    import lpc_pkg::*;
#(
    parameter int FRAME_LEN_DEF = FRAME_LEN_DEFAULT,
    parameter int ZC_HYST       = ZC_HYST_DEFAULT,
    parameter int ENERGY_THR    = ENERGY_THR_DEFAULT,
    parameter int ZC_MAX        = ZC_MAX_DEFAULT,
    parameter int MIN_PERIOD    = MIN_PERIOD_DEFAULT,
    parameter int MAX_PERIOD    = MAX_PERIOD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] x,
    input  logic        v,
    input  logic [15:0] frame_len,
    output logic        voiced,
    output logic [15:0] freq_count,
    output logic        vout
);

    localparam logic [31:0] E_THR = 32'(ENERGY_THR);
    localparam logic [15:0] Z_MAX = 16'(ZC_MAX);
    localparam logic [15:0] P_MIN = 16'(MIN_PERIOD);
    localparam logic [15:0] P_MAX = 16'(MAX_PERIOD);

    state_t      state_q, state_d;
    logic [15:0] len_q;
    logic [15:0] len_eff;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] energy_q, energy_base, energy_n;
    logic [15:0] xcnt_q, xcnt_base, xcnt_n;
    logic        frame_end;
    logic        voiced_n;
    logic        crossing;
    logic        seen_next;
    logic [15:0] last_period_next;

    lpc_zero_cross_tracker #(
        .ZC_HYST    (ZC_HYST),
        .MAX_PERIOD (MAX_PERIOD)
    ) u_tracker (
        .clk              (clk),
        .rst              (rst),
        .v                (v),
        .x                (x),
        .crossing         (crossing),
        .seen_next        (seen_next),
        .last_period_next (last_period_next)
    );

    assign len_eff = (frame_len < 16'd2) ? 16'd2 : frame_len;

    // Frame FSM: IDLE starts a frame on the first sample, ACCUM closes it when the count hits len_q
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        frame_end = 1'b0;
        case (state_q)
            IDLE: begin
                if (v) begin
                    cnt_d   = 16'd1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (v) begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_d == len_q) begin
                        frame_end = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
        endcase
    end

    // Accumulators including the current sample; a new frame starts from zero
    always_comb begin
        energy_base = (state_q == IDLE) ? 32'd0 : energy_q;
        xcnt_base   = (state_q == IDLE) ? 16'd0 : xcnt_q;
        energy_n    = energy_base + 32'(abs17(x));
        xcnt_n      = (crossing && (xcnt_base != 16'hFFFF)) ? xcnt_base + 16'd1 : xcnt_base;
        voiced_n    = (energy_n >= E_THR) && (xcnt_n >= 16'd2) && (xcnt_n <= Z_MAX) &&
                      seen_next && (last_period_next >= P_MIN) && (last_period_next <= P_MAX);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Counters, accumulators and the frame-result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= 16'(FRAME_LEN_DEF);
            cnt_q      <= '0;
            energy_q   <= '0;
            xcnt_q     <= '0;
            voiced     <= 1'b0;
            freq_count <= '0;
            vout       <= 1'b0;
        end else begin
            vout <= frame_end;
            if (v) begin
                cnt_q    <= cnt_d;
                energy_q <= energy_n;
                xcnt_q   <= xcnt_n;
                if (state_q == IDLE)
                    len_q <= len_eff;
            end
            if (frame_end) begin
                voiced     <= voiced_n;
                freq_count <= voiced_n ? last_period_next : 16'd0;
            end
        end
    end

endmodule

// File: doc/lpc_pitch_voicing.md
Name: lpc_pitch_voicing

Overview:
Per-frame pitch and voicing analyser in the LPC encoder path. It runs on the same sample stream as the LPC coefficient stage. Per frame it produces the voiced flag and the pitch period (freq_count) that LPCdec consumes as voiced and pulserate. A frame-done strobe (vout) is aligned with the coefficient outputs.

Parameters:
FRAME_LEN_DEF, 240, frame length used after reset until frame_len is written
ZC_HYST, 256, crossing hysteresis magnitude; must be non-negative
ENERGY_THR, 120000, minimum per-frame sum of |x| for voiced
ZC_MAX, 60, maximum hysteretic positive crossings per frame for voiced
MIN_PERIOD, 20, smallest valid pitch period in samples (400 Hz at 8 kHz)
MAX_PERIOD, 160, largest valid pitch period in samples (50 Hz at 8 kHz)

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  synchronous, active-high reset
x  in  16  signed sample, two's complement
v  in  1  sample strobe; x is accepted on every clk edge where v=1 (one cycle per sample; synchronised upstream)
frame_len  in  16  frame length in samples; values <2 are treated as 2
voiced  out  1  1 = frame voiced
freq_count  out  16  pitch period in samples if voiced, else 0
vout  out  1  one-cycle frame-done strobe

Behaviour:
- Reset, checked first every cycle: voiced=0, freq_count=0, vout=0. All counters, accumulators and the armed/seen flags clear. The FSM goes to IDLE. Reset mid-frame discards the partial frame and produces no vout.
- FSM states:
  - IDLE: no frame in progress. On v=1, latch the effective frame length into len_q (frame_len clamped to a minimum of 2), process the sample, set sample_cnt=1, and go to ACCUM.
  - ACCUM: on each v=1, process the sample and increment sample_cnt. On the sample where sample_cnt reaches len_q, run the frame decision and go to IDLE.
- frame_len is sampled only at frame start. A change mid-frame takes effect on the next frame.
- Per-sample processing:
  - Energy: energy += |x|. |x| is 17-bit, so |-32768| = 32768. The accumulator is 32-bit unsigned and cannot overflow for len_q ≤ 65535.
  - Arming: armed is set when x < -ZC_HYST.
  - Positive crossing: occurs when armed=1 and x ≥ +ZC_HYST. On a crossing: clear armed and increment xcnt (saturating at 16'hFFFF).
    - If seen=1, last_period <= per_cnt.
    - Then per_cnt <= 1 and seen <= 1.
  - Otherwise per_cnt increments, saturating at MAX_PERIOD+1.
  - per_cnt, seen, armed and last_period persist across frame boundaries. energy and xcnt reset at each frame start.
- Frame decision uses accumulators that include the final sample, evaluated combinationally in the cycle that sample is accepted:
  - voiced_n = (energy ≥ ENERGY_THR) && (xcnt ≥ 2) && (xcnt ≤ ZC_MAX) && seen && (MIN_PERIOD ≤ last_period ≤ MAX_PERIOD).
  - On the following edge: voiced <= voiced_n, freq_count <= voiced_n ? last_period : 0, vout <= 1.
- Latency and strobe: vout is high exactly one clk cycle, starting the cycle after the final sample is accepted. voiced and freq_count hold until the next frame decision or reset.
- Back-to-back samples: a sample arriving in the cycle immediately after the final sample (while vout=1) starts the next frame normally. No sample is ever dropped.
- With v=0 the block holds all state.

Decomposition:
- lpc_pkg holds ZC_HYST, ENERGY_THR, ZC_MAX, MIN_PERIOD, MAX_PERIOD and FRAME_LEN_DEF defaults, plus the FSM state encoding (IDLE, ACCUM).
- One sub-module, lpc_zero_cross_tracker, contains the armed/seen/per_cnt/last_period logic and the crossing strobe. The parent holds the FSM, sample counter, energy and xcnt accumulators, and the output registers.

Test Plan:
- Silence: 240 samples of x=0, v=1 every cycle -> vout=1 one cycle after the 240th sample; voiced=0; freq_count=0.
- Square wave ±8000 with period 80 (40 high, 40 low) over 3 frames of 240 -> from frame 2 on, voiced=1 and freq_count=80.
- Alternating +8000/-8000 every 2 samples for 240 samples -> xcnt=60 passes ZC_MAX, but period 4 < MIN_PERIOD -> voiced=0, freq_count=0. Repeating the stimulus every sample -> xcnt=120 > ZC_MAX -> voiced=0.
- Square wave ±200 with period 80 -> no crossings (inside hysteresis) and energy 48000 < thr -> voiced=0, freq_count=0.
- Reset asserted at sample 100 of a voiced frame -> outputs 0 next cycle, no vout; the following 240 samples form a fresh frame.
- frame_len=240, then frame_len written to 160 mid-frame -> the current frame's vout comes after 240 samples, the next after 160. frame_len=0 -> vout after every 2 samples.
